// File: rtl/d_sram_like_to_axi.sv
// d_sram_like_to_axi: data-side bridge from the CPU sram-like handshake to a
// single-beat AXI master port. One transaction in flight at a time.
// Optional feature macro: D_AXI_EARLY_WRESP_EN -- when defined, a write reports
// data_data_ok as soon as AW and W are both accepted, then waits for B before
// accepting the next request.
//
// Handshake rule used on every AXI channel: a beat transfers on the rising edge
// where valid and ready are both high; a raised valid stays high with stable
// payload until that edge.
module d_sram_like_to_axi #(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    // sram-like side
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    // debug: current FSM state
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_REQ = 3'd3,
        WR_B   = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic [1:0]  size_q, size_d;
    logic        wr_q, wr_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [1:0]  size_eff;
    logic        unused_inputs;

    // Next-state, latching and handshake outputs of the transaction FSM.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        wr_d         = wr_q;
        data_rdata_d = data_rdata_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (state_q)
            IDLE: begin
                // No acceptance while reset is being applied.
                data_addr_ok = data_req & ~rst;
                if (data_addr_ok) begin
                    addr_d    = data_addr;
                    wdata_d   = data_wdata;
                    size_d    = data_size;
                    wr_d      = data_wr;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = data_wr ? WR_REQ : RD_AR;
                end
            end
            RD_AR: begin
                arvalid = 1'b1;
                if (arready) state_d = RD_R;
            end
            RD_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_rdata_d = rdata;
                    state_d      = RESP;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; move on once both are done.
                awvalid   = ~aw_done_q;
                wvalid    = ~w_done_q;
                aw_done_d = aw_done_q | (awvalid & awready);
                w_done_d  = w_done_q | (wvalid & wready);
                if (aw_done_d && w_done_d) begin
`ifdef D_AXI_EARLY_WRESP_EN
                    state_d = RESP;
`else
                    state_d = WR_B;
`endif
                end
            end
            WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
`ifdef D_AXI_EARLY_WRESP_EN
                    state_d = IDLE;
`else
                    state_d = RESP;
`endif
                end
            end
            RESP: begin
                data_data_ok = 1'b1;
                state_d      = IDLE;
`ifdef D_AXI_EARLY_WRESP_EN
                // Write already reported; still owe the B handshake.
                if (wr_q) state_d = WR_B;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-transaction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            size_q       <= 2'd0;
            wr_q         <= 1'b0;
            data_rdata_q <= 32'd0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            wr_q         <= wr_d;
            data_rdata_q <= data_rdata_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    // Byte-lane strobes derived from the latched size and low address bits.
    always_comb begin
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    // Size 3 is not a legal sram-like size; treat it as a word.
    assign size_eff   = (size_q == 2'd3) ? 2'd2 : size_q;

    assign arid       = RD_ID;
    assign araddr     = addr_q;
    assign arlen      = 8'd0;
    assign arsize     = {1'b0, size_eff};
    assign awid       = WR_ID;
    assign awaddr     = addr_q;
    assign awlen      = 8'd0;
    assign awsize     = {1'b0, size_eff};
    assign wid        = WR_ID;
    assign wdata      = wdata_q;
    assign wlast      = 1'b1;
    assign data_rdata = data_rdata_q;
    assign dbg_state  = state_q;

    // Response ids/codes carry no information for this single-outstanding port.
    assign unused_inputs = ^{rid, rresp, rlast, bid, bresp, wr_q};

endmodule

// File: doc/d_sram_like_to_axi.md
# d_sram_like_to_axi

Data-side bridge from the CPU's sram-like handshake to a single-beat AXI master port. It sits between the data-memory sram-like converter and the AXI crossbar/cache port. It accepts one transaction at a time, latches it, drives the AXI read (AR/R) or write (AW/W/B) channels, and returns a one-cycle `data_data_ok` pulse with registered read data.

## Interface
- `RD_ID`, 4'd0: constant driven on `arid`.
- `WR_ID`, 4'd1: constant driven on `awid`/`wid`.
- `clk` in 1: the only clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `data_req` in 1: sram-like request valid.
- `data_wr` in 1: 1 = write, 0 = read.
- `data_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `data_addr` in 32: byte address.
- `data_wdata` in 32: write data, byte lanes aligned to address.
- `data_addr_ok` out 1: request accepted this cycle.
- `data_data_ok` out 1: one-cycle completion pulse.
- `data_rdata` out 32: read data, valid while `data_data_ok` = 1 and held afterwards.
- `arid`[4], `araddr`[32], `arlen`[8], `arsize`[3], `arvalid` out; `arready` in.
- `rid`[4], `rdata`[32], `rresp`[2], `rlast`, `rvalid` in; `rready` out.
- `awid`[4], `awaddr`[32], `awlen`[8], `awsize`[3], `awvalid` out; `awready` in.
- `wid`[4], `wdata`[32], `wstrb`[4], `wlast`, `wvalid` out; `wready` in.
- `bid`[4], `bresp`[2], `bvalid` in; `bready` out.

## Operation
- FSM states: IDLE, RD_AR, RD_R, WR_REQ, WR_B, RESP.
- IDLE:
  - `data_addr_ok = data_req` (combinational). This is the only state in which a request is accepted.
  - On acceptance, latch addr, size, wr and wdata. Go to WR_REQ if wr, otherwise RD_AR.
- RD_AR:
  - `arvalid` = 1 with latched address.
  - Go to RD_R on `arvalid & arready`.
- RD_R:
  - `rready` = 1.
  - On `rvalid`, register `rdata` into `data_rdata` and go to RESP.
- WR_REQ:
  - `awvalid` and `wvalid` are both raised on entry.
  - Each drops independently after its own handshake; per-channel done flags are kept.
  - When both channels are done (same or different cycles), go to WR_B.
- WR_B:
  - `bready` = 1.
  - On `bvalid`, go to RESP.
- RESP: `data_data_ok` = 1 for exactly one cycle, then IDLE.
- Constant AXI fields:
  - `arlen` = `awlen` = 0, `wlast` = 1.
  - Other constant fields: `arburst`/`awburst` are not present; downstream ties them to INCR.
- Size mapping: `arsize` = `awsize` = {1'b0, size}, with size 3 mapped to 3'b010.
- `wstrb`:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - else: 4'b1111.
- `rresp`, `bresp`, `rid` and `bid` are ignored. There is no error signalling.
- Boundary conditions:
  - A request arriving in any non-IDLE state gets `data_addr_ok` = 0 and must be held by the requester.
  - `data_req` deasserted in IDLE causes no action.
  - AW and W handshaking in the same cycle is legal, as is either one first.
  - `rvalid` is only sampled in RD_R and `bvalid` only in WR_B.

## Timing
- Reset values:
  - state = IDLE.
  - `data_addr_ok`, `data_data_ok`, `arvalid`, `awvalid`, `wvalid`, `rready`, `bready` = 0.
  - `data_rdata` = 0.
  - Latched address/data = 0.
- Reset mid-transaction aborts to IDLE the next edge and drops all valids. A system-wide reset is assumed, so no AXI drain is performed.
- Zero-wait slave, read: accepted at cycle 0, `arvalid` at 1, R handshake at 2, `data_data_ok` with data at 3.
- Zero-wait slave, write: accepted at 0, AW+W at 1, B at 2, `data_data_ok` at 3.
- Earliest next `data_addr_ok` is the cycle after RESP.
- Throughput is at most one transaction per 4 cycles.

## Configuration
- Macro: `D_AXI_EARLY_WRESP_EN`.
- Defined:
  - Writes take the path WR_REQ → RESP as soon as both AW and W are done, then → WR_B.
  - `data_data_ok` fires before `bvalid`.
  - In WR_B, `bready` = 1 and `data_addr_ok` = 0. Go to IDLE on `bvalid`.
  - Zero-wait write completes with `data_data_ok` at cycle 2. The next acceptance still waits for B.
- Undefined: behaviour as described above, with `data_data_ok` only after the B handshake.

## Test plan
- Read, zero-wait slave:
  - Stimulus: req, addr 0x1FC0_0010, size 2, rdata 0xDEADBEEF.
  - Response: `data_addr_ok` at cycle 0, `arvalid` at 1 with `arsize` = 2, `data_data_ok` at 3 with `data_rdata` = 0xDEADBEEF, held afterwards.
- Byte write:
  - Stimulus: addr 0x8000_0003, size 0, wdata 0x5500_0000.
  - Response: `wstrb` = 4'b1000, `awsize` = 0, `wlast` = 1, one `data_data_ok` pulse after `bvalid`.
- Split write handshakes:
  - Stimulus: `wready` 3 cycles before `awready`; halfword write at addr[1] = 1.
  - Response: `wvalid` drops after its handshake, `awvalid` holds until `awready`, `wstrb` = 4'b1100, single completion pulse.
- Back-to-back requests:
  - Stimulus: `data_req` held high continuously; slave `rvalid` delayed 5 cycles.
  - Response: `data_addr_ok` stays 0 until the cycle after RESP, and exactly one AR is issued per accepted request.
- Reset mid-read:
  - Stimulus: `rst` pulsed while in RD_R.
  - Response: all valids 0 and state IDLE next cycle, no `data_data_ok`, and a later `rvalid` is ignored.
- `D_AXI_EARLY_WRESP_EN` defined:
  - Stimulus: zero-wait write, then a read with `bvalid` delayed 4 cycles.
  - Response: `data_data_ok` at cycle 2, and the read is not accepted until the cycle after `bvalid`.
